axi_read_arbiter: RTL

- Shares one AXI3 read channel (AR + R) between two cache requesters: port 0 = instruction cache, port 1 = data cache.
- One outstanding burst at a time, granted round-robin. The grant is held from AR acceptance through the final R beat.
- Sits between the cache instances and the top-level AXI crossbar. The write channels bypass this block.

---
 rtl/axi_read_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI3 read channel (AR + R) between the
// instruction cache (port 0) and the data cache (port 1). One burst is in
// flight at a time; grant is round-robin and is held from AR acceptance
// through the final R beat.
module axi_read_arbiter #(
  parameter int unsigned ID_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [63:0]         s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [5:0]          s_arsize,
  input  logic [3:0]          s_arburst,
  input  logic [1:0]          s_arvalid,
  output logic [1:0]          s_arready,
  output logic [31:0]         s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic [1:0]          s_rvalid,
  input  logic [1:0]          s_rready,
  output logic [ID_WIDTH-1:0] m_arid,
  output logic [31:0]         m_araddr,
  output logic [3:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [ID_WIDTH-1:0] m_rid,
  input  logic [31:0]         m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic                protocol_err
);

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                grant;
  logic                last_grant;
  logic                winner;
  logic [LEN_W-1:0]    beat_cnt;
  logic [LEN_W-1:0]    exp_len;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LEN_W-1:0]    sel_len;
  logic [SIZE_W-1:0]   sel_size;
  logic [BURST_W-1:0]  sel_burst;
  logic                ar_fire;
  logic                r_beat;
  logic                rid_bad;
  logic                err_set;

  // R payload is broadcast; only the valids are steered
  assign s_rdata = m_rdata;
  assign s_rresp = m_rresp;
  assign s_rlast = m_rlast;

  // AR field mux for the granted requester
  assign sel_addr  = grant ? s_araddr[63:32] : s_araddr[31:0];
  assign sel_len   = grant ? s_arlen[7:4]    : s_arlen[3:0];
  assign sel_size  = grant ? s_arsize[5:3]   : s_arsize[2:0];
  assign sel_burst = grant ? s_arburst[3:2]  : s_arburst[1:0];

  assign ar_fire = (state == ADDR) && s_arvalid[grant] && m_arready;
  assign r_beat  = (state == DATA) && m_rvalid && s_rready[grant];
  assign rid_bad = (m_rid[0] != grant) || ((m_rid >> 1) != '0);

  // Unexpected R traffic outside DATA, or a beat that disagrees with the burst
  assign err_set = ((state != DATA) && m_rvalid) ||
                   (r_beat && (rid_bad ||
                               (m_rlast && (beat_cnt != exp_len)) ||
                               (!m_rlast && (beat_cnt == exp_len))));

  // Round-robin pick: a lone requester wins, ties go to the one not served last
  always_comb begin
    winner = 1'b0;
    case (s_arvalid)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|s_arvalid) state_nxt = ADDR;
      ADDR: begin
        if (ar_fire)                state_nxt = DATA;
        else if (!s_arvalid[grant]) state_nxt = IDLE;
      end
      DATA: if (r_beat && m_rlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: AR forwarded in ADDR, R handshakes steered in DATA
  always_comb begin
    m_arid    = '0;
    m_araddr  = '0;
    m_arlen   = '0;
    m_arsize  = '0;
    m_arburst = '0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    s_arready = '0;
    s_rvalid  = '0;
    case (state)
      ADDR: begin
        m_arid    = ID_WIDTH'(grant);
        m_araddr  = sel_addr;
        m_arlen   = sel_len;
        m_arsize  = sel_size;
        m_arburst = sel_burst;
        m_arvalid = s_arvalid[grant];
        s_arready = {grant & m_arready, ~grant & m_arready};
      end
      DATA: begin
        m_rready = s_rready[grant];
        s_rvalid = {grant & m_rvalid, ~grant & m_rvalid};
      end
      default: ;
    endcase
  end

  // Grant history, burst tracking and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      beat_cnt     <= '0;
      exp_len      <= '0;
      protocol_err <= 1'b0;
    end else begin
      if ((state == IDLE) && (|s_arvalid)) grant <= winner;
      if (ar_fire) begin
        exp_len  <= sel_len;
        beat_cnt <= '0;
      end else if (r_beat && (beat_cnt != exp_len)) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
      end
      if (r_beat && m_rlast) last_grant <= grant;
      if (err_set) protocol_err <= 1'b1;
    end
  end

endmodule
